// File: rtl/risc_instr_sequencer_if.sv
// Signal bundle between the instruction sequencer, its programming host and the RISC core.
// The host/core side uses the master modport; the sequencer uses the slave modport.
interface risc_instr_sequencer_if;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPA_W   = 4;
    localparam int unsigned OPB_W   = 8;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WORD_W-1:0] prog_data;
    logic [LEN_W-1:0]  prog_len;
    logic              start;
    logic              stop;
    logic              chain_en;
    logic [WORD_W-1:0] alu_op;
    logic              cb;

    logic [OPC_W-1:0]  opcode;
    logic [OPA_W-1:0]  operand_1;
    logic [OPB_W-1:0]  operand_2;
    logic              cin;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] result;
    logic              result_cb;
    logic              result_valid;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, stop, chain_en, alu_op, cb,
        input  opcode, operand_1, operand_2, cin, busy, done, pc, result, result_cb, result_valid
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, stop, chain_en, alu_op, cb,
        output opcode, operand_1, operand_2, cin, busy, done, pc, result, result_cb, result_valid
    );
endinterface

// File: rtl/risc_instr_sequencer.sv
// Program sequencer: issues a stored instruction list to the RISC core, holds each for a
// settle window, then captures the core result and reports it with a one-cycle strobe.
module risc_instr_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    risc_instr_sequencer_if.slave bus
);
    localparam int unsigned PC_W  = $clog2(DEPTH);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand_1;
        logic [7:0] operand_2;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    instr_t           mem_q [DEPTH];
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d, len_sat;
    logic             chain_q, chain_d;
    instr_t           instr_q, instr_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      result_q, result_d;
    logic             result_cb_q, result_cb_d;
    logic             valid_q, valid_d;

    // Requested lengths beyond the store size run the whole store.
    assign len_sat = (bus.prog_len > 5'(DEPTH)) ? LEN_W'(DEPTH) : LEN_W'(bus.prog_len);

    // Instruction store; the host may only write it while no run is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.prog_we && !busy_q && (32'(bus.prog_addr) < DEPTH)) begin
            mem_q[bus.prog_addr[PC_W-1:0]] <= instr_t'(bus.prog_data);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        chain_d     = chain_q;
        cin_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = done_q;
        result_d    = result_q;
        result_cb_d = result_cb_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.stop) begin
                    if (len_sat == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        len_d   = len_sat;
                        chain_d = bus.chain_en;
                        pc_d    = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                cin_d  = cin_q;
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cin_d   = 1'b0;
                    pc_d    = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    result_d    = bus.alu_op;
                    result_cb_d = bus.cb;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                    if (LEN_W'(pc_q) == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cin_d   = 1'b0;
                    end else begin
                        pc_d  = pc_q + PC_W'(1);
                        cin_d = chain_q & bus.cb;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Core-facing word is the entry about to be issued, zero when not running.
        instr_d = busy_d ? mem_q[pc_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            chain_q     <= 1'b0;
            instr_q     <= '0;
            cin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_cb_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            chain_q     <= chain_d;
            instr_q     <= instr_d;
            cin_q       <= cin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_cb_q <= result_cb_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.opcode       = instr_q.opcode;
    assign bus.operand_1    = instr_q.operand_1;
    assign bus.operand_2    = instr_q.operand_2;
    assign bus.cin          = cin_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pc           = 4'(pc_q);
    assign bus.result       = result_q;
    assign bus.result_cb    = result_cb_q;
    assign bus.result_valid = valid_q;
endmodule
